// File: rtl/lfsr_pkg.sv
// lfsr_pkg: width limits and maximal-length Fibonacci tap masks for lfsr_gen.
package lfsr_pkg;
  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 32;
  // Polynomial term x^k maps to state bit (W-1-k), with x^W landing on the MSB.
  function automatic logic [31:0] tap(input int w, input int k);
    return 32'd1 << ((2 * w - 1 - k) % w);
  endfunction
  function automatic logic [31:0] max_taps(input int width);
    case (width)
      3:  return tap(3, 3) | tap(3, 2);
      4:  return tap(4, 4) | tap(4, 3);
      5:  return tap(5, 5) | tap(5, 3);
      6:  return tap(6, 6) | tap(6, 5);
      7:  return tap(7, 7) | tap(7, 6);
      8:  return tap(8, 8) | tap(8, 6) | tap(8, 5) | tap(8, 4);
      9:  return tap(9, 9) | tap(9, 5);
      10: return tap(10, 10) | tap(10, 7);
      11: return tap(11, 11) | tap(11, 9);
      12: return tap(12, 12) | tap(12, 6) | tap(12, 4) | tap(12, 1);
      13: return tap(13, 13) | tap(13, 4) | tap(13, 3) | tap(13, 1);
      14: return tap(14, 14) | tap(14, 5) | tap(14, 3) | tap(14, 1);
      15: return tap(15, 15) | tap(15, 14);
      16: return tap(16, 16) | tap(16, 15) | tap(16, 13) | tap(16, 4);
      17: return tap(17, 17) | tap(17, 14);
      18: return tap(18, 18) | tap(18, 11);
      19: return tap(19, 19) | tap(19, 6) | tap(19, 2) | tap(19, 1);
      20: return tap(20, 20) | tap(20, 17);
      21: return tap(21, 21) | tap(21, 19);
      22: return tap(22, 22) | tap(22, 21);
      23: return tap(23, 23) | tap(23, 18);
      24: return tap(24, 24) | tap(24, 23) | tap(24, 22) | tap(24, 17);
      25: return tap(25, 25) | tap(25, 22);
      26: return tap(26, 26) | tap(26, 6) | tap(26, 2) | tap(26, 1);
      27: return tap(27, 27) | tap(27, 5) | tap(27, 2) | tap(27, 1);
      28: return tap(28, 28) | tap(28, 25);
      29: return tap(29, 29) | tap(29, 27);
      30: return tap(30, 30) | tap(30, 6) | tap(30, 4) | tap(30, 1);
      31: return tap(31, 31) | tap(31, 28);
      32: return tap(32, 32) | tap(32, 22) | tap(32, 2) | tap(32, 1);
      default: return 32'd0;
    endcase
  endfunction
endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: combinational STEPS-fold Fibonacci shift of an LFSR state.
module lfsr_next import lfsr_pkg::*; #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(max_taps(WIDTH)),
  parameter int STEPS = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);
  logic [WIDTH-1:0] s;
  always_comb begin
    s = state;
    for (int i = 0; i < STEPS; i++) s = {s[WIDTH-2:0], ^(s & TAPS)};
  end
  assign next = s;
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with multi-step advance, zero-seed guard and wrap detect.
// Define LFSR_PERIOD_CNT_EN to add the period_count/period_valid period measurement outputs.
module lfsr_gen import lfsr_pkg::*; #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(max_taps(WIDTH)),
  parameter int STEPS = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             enable,
  output logic [WIDTH-1:0] lfsr_data,
  output logic             serial_out,
  output logic             wrap,
  output logic             zero_seed
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0] period_count,
  output logic             period_valid
`endif
);
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("lfsr_gen: WIDTH out of range");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: RESET_SEED must be non-zero");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS out of range");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_gen: TAPS MSB must be set");
  end
  logic [WIDTH-1:0] ref_seed, next;
  logic             seed_zero;
  logic [WIDTH-1:0] seed_safe;
  assign seed_zero = seed_data == '0;
  assign seed_safe = seed_zero ? WIDTH'(1) : seed_data;
  assign serial_out = lfsr_data[WIDTH-1];
  lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(STEPS)) u_next (.state(lfsr_data), .next(next));
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_data <= RESET_SEED;
      ref_seed  <= RESET_SEED;
      wrap      <= 1'b0;
      zero_seed <= 1'b0;
    end else if (load_seed) begin
      lfsr_data <= seed_safe;
      ref_seed  <= seed_safe;
      wrap      <= 1'b0;
      zero_seed <= seed_zero;
    end else begin
      lfsr_data <= enable ? next : lfsr_data;
      wrap      <= enable && next == ref_seed;
      zero_seed <= 1'b0;
    end
  end
`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] count;
  always_ff @(posedge clk) begin
    if (reset || load_seed) begin
      count        <= '0;
      period_count <= '0;
      period_valid <= 1'b0;
    end else if (enable && next == ref_seed) begin
      count        <= '0;
      period_count <= count + 1'b1;
      period_valid <= 1'b1;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end
`endif
endmodule
